uart_rx: RTL and testbench

//  Serial UART receiver, 8N1 by default, using 16x oversampling from an internal baud-tick generator.

---
 rtl/uart_rx.sv | 152 +++++++++++++++
 tb/tb_uart_rx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 16x oversampling.
// A free-running baud-tick generator divides clk down to OVERSAMPLE ticks per bit.
// Each frame is sampled at mid-bit and delivered LSB-first. A good frame gives a
// one-clk o_rx_done pulse. A bad stop bit gives a one-clk o_frame_err pulse instead.
//
// Ports:
//   clk          in   1        system clock, rising edge
//   i_rst        in   1        asynchronous, active-high reset
//   i_rx         in   1        asynchronous serial line, idle high
//   o_rx_data    out  NB_DATA  last correctly framed byte, held until the next good frame
//   o_rx_done    out  1        one-clk strobe; o_rx_data is valid on the same cycle
//   o_frame_err  out  1        one-clk strobe when the stop bit is sampled low
module uart_rx #(
  parameter int NB_DATA    = 8,
  parameter int NB_STOP    = 16,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_rx_data,
  output logic               o_rx_done,
  output logic               o_frame_err
);

  localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int TW    = $clog2(DIV);
  localparam int SMAX  = (OVERSAMPLE > NB_STOP) ? OVERSAMPLE : NB_STOP;
  localparam int SW    = (SMAX > 1) ? $clog2(SMAX) : 1;
  localparam int NW    = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [SW-1:0] MID       = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] BIT_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] STOP_LAST = SW'(NB_STOP - 1);
  localparam logic [NW-1:0] DATA_LAST = NW'(NB_DATA - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t               state;
  logic                 rx_meta;
  logic                 rx_s;
  logic [TW-1:0]        tick_cnt;
  logic                 tick;
  logic [SW-1:0]        s_cnt;
  logic [NW-1:0]        n_cnt;
  logic [NB_DATA-1:0]   shift;

  // Two-flop synchroniser. It resets to the idle line level, so a reset never
  // looks like a start bit.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      // NOTE: use non-blocking assignments so that rx_s takes the old rx_meta.
      // This keeps the two register stages.
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  // The baud tick runs free. It is never realigned to a frame, so a sample
  // point can be off by up to one tick.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  // Receive FSM. The strobes are registered and default low, so each one is
  // high for exactly one clk.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      s_cnt       <= '0;
      n_cnt       <= '0;
      shift       <= '0;
      o_rx_data   <= '0;
      o_rx_done   <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_rx_done   <= 1'b0;
      o_frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            s_cnt <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (s_cnt == MID) begin
              // The line is checked again at mid start bit. If it is high, the
              // low level was a glitch and is dropped.
              s_cnt <= '0;
              n_cnt <= '0;
              state <= rx_s ? IDLE : DATA;
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (s_cnt == BIT_LAST) begin
              shift <= {rx_s, shift[NB_DATA-1:1]};
              s_cnt <= '0;
              if (n_cnt == DATA_LAST) state <= STOP;
              else                    n_cnt <= n_cnt + 1'b1;
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (s_cnt == STOP_LAST) begin
              s_cnt <= '0;
              if (rx_s) begin
                o_rx_data <= shift;
                o_rx_done <= 1'b1;
                state     <= IDLE;
              end else begin
                o_frame_err <= 1'b1;
                state       <= BREAK;
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
        BREAK: begin
          // A held-low line gives only the single error above. Reception starts
          // again only after the line goes back to idle.
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frames checked against a frame-level model.
// The model is a queue of expected events (byte or framing error, plus start-edge
// time) and the last good byte the output must hold.
module tb_uart_rx;

  localparam int BIT_CLK = 160;   // 1_600_000 / 10_000
  localparam int LAT_MIN = 1508;  // about 9.5 bits from the start edge, +-12 clk
  localparam int LAT_MAX = 1532;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_rx;
  logic [7:0] o_rx_data;
  logic       o_rx_done;
  logic       o_frame_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_cnt = 0;

  // Expected events, in arrival order.
  bit         exp_err[$];
  logic [7:0] exp_data[$];
  int         exp_t[$];
  logic [7:0] model_last = 8'h00;

  uart_rx #(
    .NB_DATA(8), .NB_STOP(16), .CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .OVERSAMPLE(16)
  ) dut (
    .clk(clk), .i_rst(i_rst), .i_rx(i_rx),
    .o_rx_data(o_rx_data), .o_rx_done(o_rx_done), .o_frame_err(o_frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [7:0] b, input bit err);
    exp_err.push_back(err);
    exp_data.push_back(b);
    exp_t.push_back(cyc);
  endtask

  task automatic drive_bit(input logic v);
    i_rx = v;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  // Full 8N1 frame. The caller must be at a negedge. The line is left idle.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    push_exp(b, !stop_ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
    i_rx = 1'b1;
  endtask

  // Compare process. It samples 2 time units after each rising edge.
  bit         prev_pulse = 1'b0;
  bit         pulse;
  bit         e_err;
  logic [7:0] e_data;
  int         e_t;
  initial begin
    forever begin
      @(posedge clk);
      #2;
      pulse = o_rx_done | o_frame_err;
      if (o_rx_done && o_frame_err)
        check(1'b0, "done_and_err_together", 1, 0);
      if (pulse) begin
        check(!prev_pulse, "pulse_width", 2, 1);
        if (exp_err.size() == 0) begin
          check(1'b0, "unexpected_pulse", {o_frame_err, o_rx_done}, 0);
        end else begin
          e_err  = exp_err.pop_front();
          e_data = exp_data.pop_front();
          e_t    = exp_t.pop_front();
          check(o_frame_err == e_err, "pulse_kind_err", o_frame_err, e_err);
          check((cyc - e_t) >= LAT_MIN && (cyc - e_t) <= LAT_MAX, "pulse_latency",
                cyc - e_t, 1520);
          if (!e_err) model_last = e_data;
        end
      end
      if (o_rx_done) done_cnt++;
      // An expected event that is far overdue counts as a missing pulse.
      if (exp_t.size() != 0 && (cyc - exp_t[0]) > LAT_MAX + 8) begin
        check(1'b0, "missing_pulse", 0, {exp_err[0], exp_data[0]});
        void'(exp_err.pop_front());
        void'(exp_data.pop_front());
        void'(exp_t.pop_front());
      end
      check(o_rx_data == model_last, "rx_data_hold", o_rx_data, model_last);
      prev_pulse = pulse;
    end
  end

  int d0;
  int gap;
  logic [7:0] rb;
  bit rok;
  initial begin
    i_rst = 1'b1;
    i_rx  = 1'b1;
    repeat (3) @(negedge clk);
    check(o_rx_data == 8'h00, "reset_data", o_rx_data, 0);
    check(o_rx_done == 1'b0, "reset_done", o_rx_done, 0);
    check(o_frame_err == 1'b0, "reset_err", o_frame_err, 0);
    i_rst = 1'b0;
    repeat (200) @(negedge clk);

    // 1: single frame after idle.
    send_frame(8'hA5, 1'b1);
    check(o_rx_data == 8'hA5, "t1_data", o_rx_data, 8'hA5);
    repeat (300) @(negedge clk);

    // 2: back-to-back frames with no idle gap.
    d0 = done_cnt;
    send_frame(8'h00, 1'b1);
    check(o_rx_data == 8'h00, "t2_data0", o_rx_data, 8'h00);
    send_frame(8'hFF, 1'b1);
    check(o_rx_data == 8'hFF, "t2_data1", o_rx_data, 8'hFF);
    check(done_cnt - d0 == 2, "t2_done_count", done_cnt - d0, 2);
    repeat (300) @(negedge clk);

    // 3: 30-clk low glitch, then a real frame.
    d0 = done_cnt;
    i_rx = 1'b0;
    repeat (30) @(negedge clk);
    i_rx = 1'b1;
    repeat (400) @(negedge clk);
    check(done_cnt == d0, "t3_glitch_no_done", done_cnt - d0, 0);
    send_frame(8'h3C, 1'b1);
    check(o_rx_data == 8'h3C, "t3_data", o_rx_data, 8'h3C);
    repeat (300) @(negedge clk);

    // 4: stop bit low, then the line held low for 20 bits, then a good frame.
    push_exp(8'h55, 1'b1);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      rb = 8'h55;
      drive_bit(rb[i]);
    end
    for (int i = 0; i < 21; i++) drive_bit(1'b0);
    check(o_rx_data == 8'h3C, "t4_data_kept", o_rx_data, 8'h3C);
    i_rx = 1'b1;
    repeat (320) @(negedge clk);
    send_frame(8'h81, 1'b1);
    check(o_rx_data == 8'h81, "t4_data", o_rx_data, 8'h81);
    repeat (300) @(negedge clk);

    // 5: reset pulse during data bit 4 of 0xF0. Bits 4..7 and stop are high, so
    // no falling edge follows the reset.
    d0 = done_cnt;
    rb = 8'hF0;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(rb[i]);
    i_rx = 1'b1;
    repeat (40) @(negedge clk);
    i_rst = 1'b1;
    model_last = 8'h00;
    #1;
    check(o_rx_data == 8'h00, "t5_reset_data", o_rx_data, 0);
    check(o_rx_done == 1'b0 && o_frame_err == 1'b0, "t5_reset_pulses",
          {o_rx_done, o_frame_err}, 0);
    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    repeat (BIT_CLK * 5 - 43) @(negedge clk);
    repeat (320) @(negedge clk);
    check(done_cnt == d0, "t5_no_done", done_cnt - d0, 0);
    send_frame(8'h7E, 1'b1);
    check(o_rx_data == 8'h7E, "t5_data", o_rx_data, 8'h7E);
    repeat (300) @(negedge clk);

    // 6: upstream sequence for the ALU interface.
    d0 = done_cnt;
    send_frame(8'h08, 1'b1);
    send_frame(8'h12, 1'b1);
    send_frame(8'h10, 1'b1);
    send_frame(8'h34, 1'b1);
    send_frame(8'h20, 1'b1);
    send_frame(8'h20, 1'b1);
    check(done_cnt - d0 == 6, "t6_done_count", done_cnt - d0, 6);
    check(o_rx_data == 8'h20, "t6_last", o_rx_data, 8'h20);
    repeat (200) @(negedge clk);

    // Random frames with random gaps and some framing errors.
    for (int k = 0; k < 16; k++) begin
      rb  = 8'($urandom);
      rok = ($urandom_range(0, 5) != 0);
      gap = $urandom_range(0, 200);
      if (!rok && gap < 16) gap = 16;
      send_frame(rb, rok);
      repeat (gap) @(negedge clk);
    end

    // Drain: all expected events must arrive within a bounded time.
    for (int w = 0; w < 3000 && exp_t.size() != 0; w++) @(negedge clk);
    check(exp_t.size() == 0, "drain_queue_empty", exp_t.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
